// File: rtl/axil_reg_slice_skid_if.sv
// ----------------------------------------------------------------------------
// axil_reg_slice_skid_if
// AXI4-Lite bundle covering all five channels (AW, W, B, AR, R).
//   master modport : drives AW/W/AR payload+valid, bready, rready
//   slave  modport : drives awready, wready, arready, B and R payload+valid
// Parameters: ADDR_WIDTH (awaddr/araddr), DATA_WIDTH (wdata/rdata; wstrb is
// DATA_WIDTH/8).
// ----------------------------------------------------------------------------
interface axil_reg_slice_skid_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_slice_skid.sv
// ----------------------------------------------------------------------------
// axil_reg_slice_skid
// Full-throughput AXI4-Lite register slice. Every channel passes through a
// two-entry skid buffer so all outputs (valids, readies and payloads) come
// straight from flops and no combinational path crosses the slice.
//   clock  : single clock
//   reset  : synchronous, active-high
//   s_axi  : upstream side (slave modport), AW/W/AR in, B/R out
//   m_axi  : downstream side (master modport), AW/W/AR out, B/R in
// ----------------------------------------------------------------------------

// One skid-buffer channel: main register feeds the output, skid register
// catches the beat that arrives in the cycle the output stalls.
//   i_in_valid/o_in_ready/i_in_data     : upstream side of the channel
//   o_out_valid/i_out_ready/o_out_data  : downstream side of the channel
module axil_skid_chan #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);
  logic             r_main_valid;
  logic [WIDTH-1:0] r_main_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_in_ready;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_load;
  logic w_skid_valid_nxt;

  assign w_in_fire   = i_in_valid & r_in_ready;
  assign w_out_fire  = r_main_valid & i_out_ready;
  // Main can take a new beat when it is empty or being drained this cycle.
  assign w_main_load = !r_main_valid || w_out_fire;

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (w_main_load) begin
      // Skid (if any) moves into main; input can only land in main here.
      w_skid_valid_nxt = 1'b0;
    end else if (w_in_fire) begin
      w_skid_valid_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // NOTE: payload registers are reset too, so data outputs read 0 in reset.
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      // Registered ready: accept next cycle only if skid will be free.
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_main_load) begin
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_data  <= r_skid_data;
        end else if (w_in_fire) begin
          r_main_valid <= 1'b1;
          r_main_data  <= i_in_data;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_fire) begin
        r_skid_data <= i_in_data;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_main_valid;
  assign o_out_data  = r_main_data;
endmodule

module axil_reg_slice_skid #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  axil_reg_slice_skid_if.slave   s_axi,
  axil_reg_slice_skid_if.master  m_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH;
  localparam int R_WIDTH    = DATA_WIDTH + 2;

  logic [W_WIDTH-1:0] w_w_in_data;
  logic [W_WIDTH-1:0] w_w_out_data;
  logic [R_WIDTH-1:0] w_r_in_data;
  logic [R_WIDTH-1:0] w_r_out_data;

  assign w_w_in_data                 = {s_axi.wdata, s_axi.wstrb};
  assign {m_axi.wdata, m_axi.wstrb}  = w_w_out_data;
  assign w_r_in_data                 = {m_axi.rdata, m_axi.rresp};
  assign {s_axi.rdata, s_axi.rresp}  = w_r_out_data;

  // AW: upstream -> downstream
  axil_skid_chan #(.WIDTH(ADDR_WIDTH)) u_aw (
    .i_clock(clock), .i_reset(reset),
    .i_in_valid(s_axi.awvalid), .o_in_ready(s_axi.awready), .i_in_data(s_axi.awaddr),
    .o_out_valid(m_axi.awvalid), .i_out_ready(m_axi.awready), .o_out_data(m_axi.awaddr)
  );

  // W: upstream -> downstream, data and strobe travel together
  axil_skid_chan #(.WIDTH(W_WIDTH)) u_w (
    .i_clock(clock), .i_reset(reset),
    .i_in_valid(s_axi.wvalid), .o_in_ready(s_axi.wready), .i_in_data(w_w_in_data),
    .o_out_valid(m_axi.wvalid), .i_out_ready(m_axi.wready), .o_out_data(w_w_out_data)
  );

  // B: downstream -> upstream
  axil_skid_chan #(.WIDTH(2)) u_b (
    .i_clock(clock), .i_reset(reset),
    .i_in_valid(m_axi.bvalid), .o_in_ready(m_axi.bready), .i_in_data(m_axi.bresp),
    .o_out_valid(s_axi.bvalid), .i_out_ready(s_axi.bready), .o_out_data(s_axi.bresp)
  );

  // AR: upstream -> downstream
  axil_skid_chan #(.WIDTH(ADDR_WIDTH)) u_ar (
    .i_clock(clock), .i_reset(reset),
    .i_in_valid(s_axi.arvalid), .o_in_ready(s_axi.arready), .i_in_data(s_axi.araddr),
    .o_out_valid(m_axi.arvalid), .i_out_ready(m_axi.arready), .o_out_data(m_axi.araddr)
  );

  // R: downstream -> upstream, data and response travel together
  axil_skid_chan #(.WIDTH(R_WIDTH)) u_r (
    .i_clock(clock), .i_reset(reset),
    .i_in_valid(m_axi.rvalid), .o_in_ready(m_axi.rready), .i_in_data(w_r_in_data),
    .o_out_valid(s_axi.rvalid), .i_out_ready(s_axi.rready), .o_out_data(w_r_out_data)
  );
endmodule

// File: tb/tb_axil_reg_slice_skid.sv
// ----------------------------------------------------------------------------
// tb_axil_reg_slice_skid
// Directed bench for axil_reg_slice_skid. Inputs change 1 time unit after the
// rising edge and outputs are sampled at that same point, before new inputs.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axil_reg_slice_skid;
  logic clock;
  logic reset;

  axil_reg_slice_skid_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
  axil_reg_slice_skid_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  axil_reg_slice_skid #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .s_axi (s_if.slave),
    .m_axi (m_if.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // AW backpressure / pass-through vectors: inputs applied before an edge,
  // expected outputs observed just after it.
  typedef struct {
    logic        in_valid;
    logic [31:0] in_addr;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_in_ready;
  } aw_vec_t;

  aw_vec_t aw_vecs[10];

  initial begin
    // A=0x100 B=0x104 C=0x108 D=0x10C E=0x110
    aw_vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1}; // A into main
    aw_vecs[1] = '{1'b1, 32'h104, 1'b0, 1'b1, 32'h100, 1'b0}; // B into skid, ready drops
    aw_vecs[2] = '{1'b1, 32'h108, 1'b0, 1'b1, 32'h100, 1'b0}; // C held
    aw_vecs[3] = '{1'b1, 32'h108, 1'b0, 1'b1, 32'h100, 1'b0}; // C held
    aw_vecs[4] = '{1'b1, 32'h108, 1'b1, 1'b1, 32'h104, 1'b1}; // A out, B to main
    aw_vecs[5] = '{1'b1, 32'h108, 1'b1, 1'b1, 32'h108, 1'b1}; // B out, C accepted
    aw_vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h108, 1'b1}; // C out, empty
    aw_vecs[7] = '{1'b1, 32'h10C, 1'b1, 1'b1, 32'h10C, 1'b1}; // D accepted
    aw_vecs[8] = '{1'b1, 32'h110, 1'b1, 1'b1, 32'h110, 1'b1}; // D out + E in, same edge
    aw_vecs[9] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h110, 1'b1}; // E out
  end

  initial begin
    reset = 1'b1;
    s_if.awaddr = '0; s_if.awvalid = 1'b0;
    s_if.wdata = '0;  s_if.wstrb = '0; s_if.wvalid = 1'b0;
    s_if.bready = 1'b0;
    s_if.araddr = '0; s_if.arvalid = 1'b0;
    s_if.rready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.bresp = '0; m_if.bvalid = 1'b0;
    m_if.arready = 1'b0;
    m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 1'b0;

    // ---------------- Reset / idle ----------------
    repeat (3) tick();
    check("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
    check("rst_m_wvalid",  64'(m_if.wvalid),  64'd0);
    check("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check("rst_s_bvalid",  64'(s_if.bvalid),  64'd0);
    check("rst_s_rvalid",  64'(s_if.rvalid),  64'd0);
    check("rst_s_awready", 64'(s_if.awready), 64'd0);
    check("rst_s_wready",  64'(s_if.wready),  64'd0);
    check("rst_s_arready", 64'(s_if.arready), 64'd0);
    check("rst_m_bready",  64'(m_if.bready),  64'd0);
    check("rst_m_rready",  64'(m_if.rready),  64'd0);
    check("rst_data", {m_if.awaddr, m_if.araddr}, 64'd0);
    check("rst_wdata", {m_if.wdata, 28'd0, m_if.wstrb}, 64'd0);
    check("rst_rdata", {s_if.rdata, 26'd0, s_if.rresp, 2'd0, s_if.bresp, 2'd0}, 64'd0);

    reset = 1'b0;
    tick();
    check("rel_s_awready", 64'(s_if.awready), 64'd1);
    check("rel_s_wready",  64'(s_if.wready),  64'd1);
    check("rel_s_arready", 64'(s_if.arready), 64'd1);
    check("rel_m_bready",  64'(m_if.bready),  64'd1);
    check("rel_m_rready",  64'(m_if.rready),  64'd1);

    // ---------------- Single write ----------------
    m_if.awready = 1'b1; m_if.wready = 1'b1; s_if.bready = 1'b1;
    s_if.awaddr = 32'h0000_0500; s_if.awvalid = 1'b1;
    s_if.wdata = 32'h1234_5678;  s_if.wstrb = 4'hF; s_if.wvalid = 1'b1;
    tick();
    check("wr_m_awvalid", 64'(m_if.awvalid), 64'd1);
    check("wr_m_awaddr",  64'(m_if.awaddr),  64'h500);
    check("wr_m_wvalid",  64'(m_if.wvalid),  64'd1);
    check("wr_m_wdata",   64'(m_if.wdata),   64'h1234_5678);
    check("wr_m_wstrb",   64'(m_if.wstrb),   64'hF);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
    tick();
    check("wr_m_awvalid_done", 64'(m_if.awvalid), 64'd0);
    check("wr_m_wvalid_done",  64'(m_if.wvalid),  64'd0);
    check("b_s_bvalid", 64'(s_if.bvalid), 64'd1);
    check("b_s_bresp",  64'(s_if.bresp),  64'd0);
    m_if.bresp = 2'b10; // second response, SLVERR, passes unmodified
    tick();
    check("b2_s_bvalid", 64'(s_if.bvalid), 64'd1);
    check("b2_s_bresp",  64'(s_if.bresp),  64'd2);
    m_if.bvalid = 1'b0;
    tick();
    check("b_s_bvalid_done", 64'(s_if.bvalid), 64'd0);

    // ---------------- Streaming read ----------------
    m_if.arready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_if.araddr = 32'(i * 4); s_if.arvalid = 1'b1;
      tick();
      check($sformatf("ar_stream_valid[%0d]", i), 64'(m_if.arvalid), 64'd1);
      check($sformatf("ar_stream_addr[%0d]", i),  64'(m_if.araddr),  64'(i * 4));
      check($sformatf("ar_stream_ready[%0d]", i), 64'(s_if.arready), 64'd1);
    end
    s_if.arvalid = 1'b0;
    tick();
    check("ar_stream_end", 64'(m_if.arvalid), 64'd0);

    // ---------------- AW backpressure table ----------------
    for (int i = 0; i < 10; i++) begin
      s_if.awvalid = aw_vecs[i].in_valid;
      s_if.awaddr  = aw_vecs[i].in_addr;
      m_if.awready = aw_vecs[i].out_ready;
      tick();
      check($sformatf("aw_vec%0d_valid", i), 64'(m_if.awvalid), 64'(aw_vecs[i].exp_valid));
      check($sformatf("aw_vec%0d_addr", i),  64'(m_if.awaddr),  64'(aw_vecs[i].exp_addr));
      check($sformatf("aw_vec%0d_ready", i), 64'(s_if.awready), 64'(aw_vecs[i].exp_in_ready));
    end

    // ---------------- R-channel stall ----------------
    s_if.rready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hDEAD_BEEF; m_if.rresp = 2'b00;
    tick();
    check("r_first_valid", 64'(s_if.rvalid), 64'd1);
    check("r_first_data",  64'(s_if.rdata),  64'hDEAD_BEEF);
    check("r_first_ready", 64'(m_if.rready), 64'd1);
    m_if.rdata = 32'hCAFE_F00D; m_if.rresp = 2'b01;
    tick();
    check("r_second_ready", 64'(m_if.rready), 64'd0);
    m_if.rvalid = 1'b0; m_if.rdata = 32'h0; m_if.rresp = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("r_hold%0d_valid", i), 64'(s_if.rvalid), 64'd1);
      check($sformatf("r_hold%0d_data", i),  {s_if.rdata, 30'd0, s_if.rresp}, {32'hDEAD_BEEF, 32'd0});
      check($sformatf("r_hold%0d_ready", i), 64'(m_if.rready), 64'd0);
    end
    s_if.rready = 1'b1;
    tick();
    check("r_drain1_valid", 64'(s_if.rvalid), 64'd1);
    check("r_drain1_data",  {s_if.rdata, 30'd0, s_if.rresp}, {32'hCAFE_F00D, 32'd1});
    check("r_drain1_ready", 64'(m_if.rready), 64'd1);
    tick();
    check("r_drain2_valid", 64'(s_if.rvalid), 64'd0);

    // ---------------- Reset mid-operation (W skid full) ----------------
    m_if.wready = 1'b0;
    s_if.wvalid = 1'b1; s_if.wdata = 32'hAAAA_0001; s_if.wstrb = 4'h3;
    tick();
    s_if.wdata = 32'hAAAA_0002; s_if.wstrb = 4'hC;
    tick();
    check("wrst_skid_full", 64'(s_if.wready), 64'd0);
    check("wrst_pre_valid", 64'(m_if.wvalid), 64'd1);
    s_if.wvalid = 1'b0;
    reset = 1'b1;
    tick();
    check("wrst_m_wvalid", 64'(m_if.wvalid), 64'd0);
    check("wrst_m_wdata",  64'(m_if.wdata),  64'd0);
    check("wrst_s_wready", 64'(s_if.wready), 64'd0);
    reset = 1'b0;
    m_if.wready = 1'b1;
    tick();
    check("wrst_rel_wready", 64'(s_if.wready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrst_no_stale%0d", i), 64'(m_if.wvalid), 64'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
